// File: rtl/rename_stage_if.sv
// rtl/rename_stage_if.sv - renamed-bundle output bus from rename to dispatch/ROB.
interface rename_stage_if #(
  parameter int PHY_WIDTH = 6
);
  logic                 out_valid_0;
  logic                 out_valid_1;
  logic                 out_rd_we_0;
  logic                 out_rd_we_1;
  logic [PHY_WIDTH-1:0] out_rs1_phy_0;
  logic [PHY_WIDTH-1:0] out_rs1_phy_1;
  logic [PHY_WIDTH-1:0] out_rs2_phy_0;
  logic [PHY_WIDTH-1:0] out_rs2_phy_1;
  logic [PHY_WIDTH-1:0] out_rd_phy_new_0;
  logic [PHY_WIDTH-1:0] out_rd_phy_new_1;
  logic [PHY_WIDTH-1:0] out_rd_phy_old_0;
  logic [PHY_WIDTH-1:0] out_rd_phy_old_1;
  logic                 out_ready;

  modport master (
    output out_valid_0, out_valid_1, out_rd_we_0, out_rd_we_1,
    output out_rs1_phy_0, out_rs1_phy_1, out_rs2_phy_0, out_rs2_phy_1,
    output out_rd_phy_new_0, out_rd_phy_new_1, out_rd_phy_old_0, out_rd_phy_old_1,
    input  out_ready
  );

  modport slave (
    input  out_valid_0, out_valid_1, out_rd_we_0, out_rd_we_1,
    input  out_rs1_phy_0, out_rs1_phy_1, out_rs2_phy_0, out_rs2_phy_1,
    input  out_rd_phy_new_0, out_rd_phy_new_1, out_rd_phy_old_0, out_rd_phy_old_1,
    output out_ready
  );
endinterface

// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - two-wide register rename with speculative/committed map tables.
module rename_stage #(
  parameter int ARCH_REGS  = 32,
  parameter int PHY_REGS   = 64,
  parameter int ARCH_WIDTH = 5,
  parameter int PHY_WIDTH  = 6,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid_0,
  input  logic                  in_valid_1,
  input  logic                  in_rd_we_0,
  input  logic                  in_rd_we_1,
  input  logic [ARCH_WIDTH-1:0] in_rd_arch_0,
  input  logic [ARCH_WIDTH-1:0] in_rd_arch_1,
  input  logic [ARCH_WIDTH-1:0] in_rs1_arch_0,
  input  logic [ARCH_WIDTH-1:0] in_rs1_arch_1,
  input  logic [ARCH_WIDTH-1:0] in_rs2_arch_0,
  input  logic [ARCH_WIDTH-1:0] in_rs2_arch_1,
  output logic                  in_ready,
  input  logic [CNT_WIDTH-1:0]  free_count,
  output logic                  alloc_req_0,
  output logic                  alloc_req_1,
  input  logic [PHY_WIDTH-1:0]  alloc_phy_0,
  input  logic [PHY_WIDTH-1:0]  alloc_phy_1,
  input  logic                  retire_valid,
  input  logic [ARCH_WIDTH-1:0] retire_rd_arch,
  input  logic [PHY_WIDTH-1:0]  retire_rd_phy,
  rename_stage_if.master        dn
);

  if (PHY_REGS < ARCH_REGS) begin : g_bad_cfg
    $error("rename_stage: PHY_REGS must cover the identity mapping of ARCH_REGS");
  end

  logic [PHY_WIDTH-1:0] srat [ARCH_REGS];
  logic [PHY_WIDTH-1:0] crat [ARCH_REGS];

  logic                 need_0, need_1, fire, out_busy;
  logic [1:0]           needed;
  logic [PHY_WIDTH-1:0] rs1_0, rs2_0, rs1_1, rs2_1, old_0, old_1, new_0, new_1;

  always_comb begin
    need_0   = in_valid_0 & in_rd_we_0 & (in_rd_arch_0 != '0);
    need_1   = in_valid_1 & in_rd_we_1 & (in_rd_arch_1 != '0);
    needed   = {1'b0, need_0} + {1'b0, need_1};
    out_busy = (dn.out_valid_0 | dn.out_valid_1) & ~dn.out_ready;
    in_ready = ~flush & ~rst & ~out_busy & (free_count >= CNT_WIDTH'(needed));
    fire     = in_ready & (in_valid_0 | in_valid_1);
    alloc_req_0 = fire & need_0;
    alloc_req_1 = fire & need_1;

    rs1_0 = (in_rs1_arch_0 == '0) ? '0 : srat[in_rs1_arch_0];
    rs2_0 = (in_rs2_arch_0 == '0) ? '0 : srat[in_rs2_arch_0];
    rs1_1 = (in_rs1_arch_1 == '0) ? '0 : srat[in_rs1_arch_1];
    rs2_1 = (in_rs2_arch_1 == '0) ? '0 : srat[in_rs2_arch_1];
    // Slot 1 must see slot 0's fresh destination, not the stale map entry.
    if (need_0 && in_rs1_arch_1 == in_rd_arch_0) rs1_1 = alloc_phy_0;
    if (need_0 && in_rs2_arch_1 == in_rd_arch_0) rs2_1 = alloc_phy_0;

    new_0 = need_0 ? alloc_phy_0 : '0;
    new_1 = need_1 ? alloc_phy_1 : '0;
    old_0 = need_0 ? srat[in_rd_arch_0] : '0;
    old_1 = '0;
    if (need_1)
      old_1 = (need_0 && in_rd_arch_0 == in_rd_arch_1) ? alloc_phy_0 : srat[in_rd_arch_1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) crat[i] <= PHY_WIDTH'(i);
    end else if (retire_valid && retire_rd_arch != '0) begin
      crat[retire_rd_arch] <= retire_rd_phy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) srat[i] <= PHY_WIDTH'(i);
    end else if (flush) begin
      // Recover to committed state, folding in a retire landing this same cycle.
      for (int i = 1; i < ARCH_REGS; i++)
        srat[i] <= (retire_valid && retire_rd_arch == ARCH_WIDTH'(i)) ? retire_rd_phy : crat[i];
      srat[0] <= '0;
    end else if (fire) begin
      if (need_0) srat[in_rd_arch_0] <= alloc_phy_0;
      if (need_1) srat[in_rd_arch_1] <= alloc_phy_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dn.out_valid_0      <= 1'b0;
      dn.out_valid_1      <= 1'b0;
      dn.out_rd_we_0      <= 1'b0;
      dn.out_rd_we_1      <= 1'b0;
      dn.out_rs1_phy_0    <= '0;
      dn.out_rs1_phy_1    <= '0;
      dn.out_rs2_phy_0    <= '0;
      dn.out_rs2_phy_1    <= '0;
      dn.out_rd_phy_new_0 <= '0;
      dn.out_rd_phy_new_1 <= '0;
      dn.out_rd_phy_old_0 <= '0;
      dn.out_rd_phy_old_1 <= '0;
    end else if (flush) begin
      dn.out_valid_0 <= 1'b0;
      dn.out_valid_1 <= 1'b0;
    end else if (fire) begin
      dn.out_valid_0      <= in_valid_0;
      dn.out_valid_1      <= in_valid_1;
      dn.out_rd_we_0      <= need_0;
      dn.out_rd_we_1      <= need_1;
      dn.out_rs1_phy_0    <= rs1_0;
      dn.out_rs1_phy_1    <= rs1_1;
      dn.out_rs2_phy_0    <= rs2_0;
      dn.out_rs2_phy_1    <= rs2_1;
      dn.out_rd_phy_new_0 <= new_0;
      dn.out_rd_phy_new_1 <= new_1;
      dn.out_rd_phy_old_0 <= old_0;
      dn.out_rd_phy_old_1 <= old_1;
    end else if (dn.out_ready) begin
      dn.out_valid_0 <= 1'b0;
      dn.out_valid_1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
// tb/tb_rename_stage.sv - directed self-checking bench for rename_stage.
module tb_rename_stage;
  logic       clk = 1'b0;
  logic       rst, flush;
  logic       in_valid_0, in_valid_1, in_rd_we_0, in_rd_we_1;
  logic [4:0] in_rd_arch_0, in_rd_arch_1, in_rs1_arch_0, in_rs1_arch_1;
  logic [4:0] in_rs2_arch_0, in_rs2_arch_1;
  logic       in_ready;
  logic [5:0] free_count;
  logic       alloc_req_0, alloc_req_1;
  logic [5:0] alloc_phy_0, alloc_phy_1;
  logic       retire_valid;
  logic [4:0] retire_rd_arch;
  logic [5:0] retire_rd_phy;
  int         total = 0;
  int         bad = 0;

  rename_stage_if #(.PHY_WIDTH(6)) dn ();

  rename_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
    .in_rd_we_0(in_rd_we_0), .in_rd_we_1(in_rd_we_1),
    .in_rd_arch_0(in_rd_arch_0), .in_rd_arch_1(in_rd_arch_1),
    .in_rs1_arch_0(in_rs1_arch_0), .in_rs1_arch_1(in_rs1_arch_1),
    .in_rs2_arch_0(in_rs2_arch_0), .in_rs2_arch_1(in_rs2_arch_1),
    .in_ready(in_ready), .free_count(free_count),
    .alloc_req_0(alloc_req_0), .alloc_req_1(alloc_req_1),
    .alloc_phy_0(alloc_phy_0), .alloc_phy_1(alloc_phy_1),
    .retire_valid(retire_valid), .retire_rd_arch(retire_rd_arch),
    .retire_rd_phy(retire_rd_phy), .dn(dn)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; retire_valid = 0; retire_rd_arch = 0; retire_rd_phy = 0;
    in_valid_0 = 0; in_valid_1 = 0; in_rd_we_0 = 0; in_rd_we_1 = 0;
    in_rd_arch_0 = 0; in_rd_arch_1 = 0; in_rs1_arch_0 = 0; in_rs1_arch_1 = 0;
    in_rs2_arch_0 = 0; in_rs2_arch_1 = 0;
    free_count = 32; alloc_phy_0 = 0; alloc_phy_1 = 0; dn.out_ready = 1;
  endtask

  task automatic slot0(input logic we, input logic [4:0] rd, rs1, rs2, input logic [5:0] ph);
    in_valid_0 = 1; in_rd_we_0 = we; in_rd_arch_0 = rd;
    in_rs1_arch_0 = rs1; in_rs2_arch_0 = rs2; alloc_phy_0 = ph;
  endtask

  task automatic slot1(input logic we, input logic [4:0] rd, rs1, rs2, input logic [5:0] ph);
    in_valid_1 = 1; in_rd_we_1 = we; in_rd_arch_1 = rd;
    in_rs1_arch_1 = rs1; in_rs2_arch_1 = rs2; alloc_phy_1 = ph;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    slot0(1, 3, 1, 2, 20); flush = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0d exp=0", in_ready); end
    total++; if (alloc_req_0 !== 1'b0) begin bad++; $display("FAIL rst_alloc_req_0 got=%0d exp=0", alloc_req_0); end
    tick(); tick();
    total++; if (dn.out_valid_0 !== 1'b0) begin bad++; $display("FAIL rst_out_valid_0 got=%0d exp=0", dn.out_valid_0); end
    total++; if (dn.out_rd_phy_new_0 !== 6'd0) begin bad++; $display("FAIL rst_new_0 got=%0d exp=0", dn.out_rd_phy_new_0); end
    idle(); rst = 0;
    tick();
  endtask

  task automatic test_basic();
    idle();
    slot0(1, 5, 1, 2, 32); slot1(1, 6, 5, 5, 33);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%0d exp=1", in_ready); end
    total++; if ({alloc_req_0, alloc_req_1} !== 2'b11) begin bad++; $display("FAIL basic_alloc_req got=%b exp=11", {alloc_req_0, alloc_req_1}); end
    tick();
    total++; if (dn.out_rs1_phy_0 !== 6'd1) begin bad++; $display("FAIL basic_rs1_0 got=%0d exp=1", dn.out_rs1_phy_0); end
    total++; if (dn.out_rs2_phy_0 !== 6'd2) begin bad++; $display("FAIL basic_rs2_0 got=%0d exp=2", dn.out_rs2_phy_0); end
    total++; if (dn.out_rd_phy_new_0 !== 6'd32) begin bad++; $display("FAIL basic_new_0 got=%0d exp=32", dn.out_rd_phy_new_0); end
    total++; if (dn.out_rd_phy_old_0 !== 6'd5) begin bad++; $display("FAIL basic_old_0 got=%0d exp=5", dn.out_rd_phy_old_0); end
    total++; if (dn.out_rs1_phy_1 !== 6'd32) begin bad++; $display("FAIL basic_rs1_1 got=%0d exp=32", dn.out_rs1_phy_1); end
    total++; if (dn.out_rs2_phy_1 !== 6'd32) begin bad++; $display("FAIL basic_rs2_1 got=%0d exp=32", dn.out_rs2_phy_1); end
    total++; if (dn.out_rd_phy_new_1 !== 6'd33) begin bad++; $display("FAIL basic_new_1 got=%0d exp=33", dn.out_rd_phy_new_1); end
    total++; if (dn.out_rd_phy_old_1 !== 6'd6) begin bad++; $display("FAIL basic_old_1 got=%0d exp=6", dn.out_rd_phy_old_1); end
    total++; if ({dn.out_valid_0, dn.out_valid_1} !== 2'b11) begin bad++; $display("FAIL basic_valid got=%b exp=11", {dn.out_valid_0, dn.out_valid_1}); end
    idle();
    tick();
    total++; if ({dn.out_valid_0, dn.out_valid_1} !== 2'b00) begin bad++; $display("FAIL drain_valid got=%b exp=00", {dn.out_valid_0, dn.out_valid_1}); end
  endtask

  task automatic test_same_rd();
    idle();
    slot0(1, 7, 0, 0, 40); slot1(1, 7, 0, 0, 41);
    tick();
    total++; if (dn.out_rd_phy_old_0 !== 6'd7) begin bad++; $display("FAIL same_old_0 got=%0d exp=7", dn.out_rd_phy_old_0); end
    total++; if (dn.out_rd_phy_old_1 !== 6'd40) begin bad++; $display("FAIL same_old_1 got=%0d exp=40", dn.out_rd_phy_old_1); end
    idle(); slot0(0, 0, 7, 6, 0);
    tick();
    total++; if (dn.out_rs1_phy_0 !== 6'd41) begin bad++; $display("FAIL same_read_x7 got=%0d exp=41", dn.out_rs1_phy_0); end
    total++; if (dn.out_rs2_phy_0 !== 6'd33) begin bad++; $display("FAIL same_read_x6 got=%0d exp=33", dn.out_rs2_phy_0); end
    total++; if (dn.out_rd_we_0 !== 1'b0) begin bad++; $display("FAIL same_rd_we_0 got=%0d exp=0", dn.out_rd_we_0); end
  endtask

  task automatic test_freelist_stall();
    idle(); free_count = 1;
    slot0(1, 8, 0, 0, 42); slot1(1, 9, 0, 0, 43);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%0d exp=0", in_ready); end
    total++; if ({alloc_req_0, alloc_req_1} !== 2'b00) begin bad++; $display("FAIL stall_alloc got=%b exp=00", {alloc_req_0, alloc_req_1}); end
    tick();
    total++; if (dn.out_valid_0 !== 1'b0) begin bad++; $display("FAIL stall_out_valid got=%0d exp=0", dn.out_valid_0); end
    free_count = 2;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL unstall_in_ready got=%0d exp=1", in_ready); end
    tick();
    total++; if (dn.out_rd_phy_old_0 !== 6'd8) begin bad++; $display("FAIL unstall_old_0 got=%0d exp=8", dn.out_rd_phy_old_0); end
    total++; if (dn.out_rd_phy_new_1 !== 6'd43) begin bad++; $display("FAIL unstall_new_1 got=%0d exp=43", dn.out_rd_phy_new_1); end
    total++; if (dn.out_rd_phy_old_1 !== 6'd9) begin bad++; $display("FAIL unstall_old_1 got=%0d exp=9", dn.out_rd_phy_old_1); end
  endtask

  task automatic test_back_pressure();
    idle(); dn.out_ready = 0;
    slot0(1, 10, 0, 0, 44);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%0d exp=0", c, in_ready); end
      total++; if (alloc_req_0 !== 1'b0) begin bad++; $display("FAIL bp_alloc cyc=%0d got=%0d exp=0", c, alloc_req_0); end
      tick();
      total++; if (dn.out_valid_0 !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%0d exp=1", c, dn.out_valid_0); end
      total++; if (dn.out_rd_phy_new_0 !== 6'd42) begin bad++; $display("FAIL bp_new_0 cyc=%0d got=%0d exp=42", c, dn.out_rd_phy_new_0); end
      total++; if (dn.out_rd_phy_new_1 !== 6'd43) begin bad++; $display("FAIL bp_new_1 cyc=%0d got=%0d exp=43", c, dn.out_rd_phy_new_1); end
    end
    dn.out_ready = 1;
    tick();
    total++; if (dn.out_rd_phy_new_0 !== 6'd44) begin bad++; $display("FAIL bp_release_new got=%0d exp=44", dn.out_rd_phy_new_0); end
    total++; if (dn.out_rd_phy_old_0 !== 6'd10) begin bad++; $display("FAIL bp_release_old got=%0d exp=10", dn.out_rd_phy_old_0); end
    total++; if (dn.out_valid_1 !== 1'b0) begin bad++; $display("FAIL bp_release_v1 got=%0d exp=0", dn.out_valid_1); end
  endtask

  task automatic test_flush();
    idle(); retire_valid = 1; retire_rd_arch = 5; retire_rd_phy = 32;
    tick();
    idle(); slot0(1, 5, 0, 0, 34);
    tick();
    total++; if (dn.out_rd_phy_old_0 !== 6'd32) begin bad++; $display("FAIL fl_old_x5 got=%0d exp=32", dn.out_rd_phy_old_0); end
    idle(); flush = 1; slot0(1, 13, 0, 0, 47);
    #1;
    total++; if (in_ready !== 1'b0 || alloc_req_0 !== 1'b0) begin bad++; $display("FAIL fl_no_fire got=%b exp=00", {in_ready, alloc_req_0}); end
    tick();
    total++; if (dn.out_valid_0 !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0d exp=0", dn.out_valid_0); end
    idle(); slot0(0, 0, 5, 6, 0);
    tick();
    total++; if (dn.out_rs1_phy_0 !== 6'd32) begin bad++; $display("FAIL fl_read_x5 got=%0d exp=32", dn.out_rs1_phy_0); end
    total++; if (dn.out_rs2_phy_0 !== 6'd6) begin bad++; $display("FAIL fl_read_x6 got=%0d exp=6", dn.out_rs2_phy_0); end
    idle(); flush = 1; retire_valid = 1; retire_rd_arch = 9; retire_rd_phy = 50;
    tick();
    idle(); slot0(0, 0, 9, 10, 0);
    tick();
    total++; if (dn.out_rs1_phy_0 !== 6'd50) begin bad++; $display("FAIL fl_read_x9 got=%0d exp=50", dn.out_rs1_phy_0); end
    total++; if (dn.out_rs2_phy_0 !== 6'd10) begin bad++; $display("FAIL fl_read_x10 got=%0d exp=10", dn.out_rs2_phy_0); end
  endtask

  task automatic test_x0();
    idle(); slot0(1, 0, 0, 0, 48); slot1(1, 0, 0, 3, 49);
    #1;
    total++; if ({alloc_req_0, alloc_req_1} !== 2'b00) begin bad++; $display("FAIL x0_alloc got=%b exp=00", {alloc_req_0, alloc_req_1}); end
    tick();
    total++; if (dn.out_valid_0 !== 1'b1 || dn.out_rd_we_0 !== 1'b0) begin bad++; $display("FAIL x0_valid_we got=%b exp=10", {dn.out_valid_0, dn.out_rd_we_0}); end
    total++; if (dn.out_rs1_phy_0 !== 6'd0) begin bad++; $display("FAIL x0_rs1 got=%0d exp=0", dn.out_rs1_phy_0); end
    total++; if (dn.out_rd_phy_new_1 !== 6'd0 || dn.out_rd_phy_old_1 !== 6'd0) begin bad++; $display("FAIL x0_new_old_1 got=%0d/%0d exp=0/0", dn.out_rd_phy_new_1, dn.out_rd_phy_old_1); end
    total++; if (dn.out_rs2_phy_1 !== 6'd3) begin bad++; $display("FAIL x0_rs2_1 got=%0d exp=3", dn.out_rs2_phy_1); end
  endtask

  task automatic test_slot1_only();
    idle(); in_rd_we_0 = 1; in_rd_arch_0 = 11; alloc_phy_0 = 46;
    slot1(1, 12, 11, 0, 45);
    #1;
    total++; if ({alloc_req_0, alloc_req_1} !== 2'b01) begin bad++; $display("FAIL s1_alloc got=%b exp=01", {alloc_req_0, alloc_req_1}); end
    tick();
    total++; if ({dn.out_valid_0, dn.out_valid_1} !== 2'b01) begin bad++; $display("FAIL s1_valid got=%b exp=01", {dn.out_valid_0, dn.out_valid_1}); end
    total++; if (dn.out_rs1_phy_1 !== 6'd11) begin bad++; $display("FAIL s1_no_bypass got=%0d exp=11", dn.out_rs1_phy_1); end
    total++; if (dn.out_rd_phy_new_1 !== 6'd45 || dn.out_rd_phy_old_1 !== 6'd12) begin bad++; $display("FAIL s1_new_old got=%0d/%0d exp=45/12", dn.out_rd_phy_new_1, dn.out_rd_phy_old_1); end
  endtask

  task automatic test_reset_dominates();
    idle(); rst = 1; flush = 1; retire_valid = 1; retire_rd_arch = 3; retire_rd_phy = 60;
    slot0(1, 5, 0, 0, 61);
    #1;
    total++; if (in_ready !== 1'b0 || alloc_req_0 !== 1'b0) begin bad++; $display("FAIL rd_no_fire got=%b exp=00", {in_ready, alloc_req_0}); end
    tick();
    total++; if (dn.out_valid_0 !== 1'b0) begin bad++; $display("FAIL rd_valid got=%0d exp=0", dn.out_valid_0); end
    idle(); rst = 0; slot0(0, 0, 3, 5, 0);
    tick();
    total++; if (dn.out_rs1_phy_0 !== 6'd3) begin bad++; $display("FAIL rd_read_x3 got=%0d exp=3", dn.out_rs1_phy_0); end
    total++; if (dn.out_rs2_phy_0 !== 6'd5) begin bad++; $display("FAIL rd_read_x5 got=%0d exp=5", dn.out_rs2_phy_0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_rd();
    test_freelist_stall();
    test_back_pressure();
    test_flush();
    test_x0();
    test_slot1_only();
    test_reset_dominates();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 SHALL have parameters ARCH_REGS, default 32, architectural register count; PHY_REGS, default 64, physical register count; ARCH_WIDTH, default 5, arch index width; PHY_WIDTH, default 6, phys index width; CNT_WIDTH, default 6, free-count width.
REQ-002 SHALL have ports as follows, one per line:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  synchronous, active-high reset
  flush  in  1  pipeline flush / mispredict recovery
  in_valid_0, in_valid_1  in  1 each  decoded instruction valid per slot
  in_rd_we_0, in_rd_we_1  in  1 each  slot writes a destination
  in_rd_arch_0/1, in_rs1_arch_0/1, in_rs2_arch_0/1  in  ARCH_WIDTH each  arch register indices
  in_ready  out  1  bundle accepted this cycle
  free_count  in  CNT_WIDTH  free physical registers reported by the freelist
  alloc_req_0, alloc_req_1  out  1 each  allocation requests to freelist buses 0/1
  alloc_phy_0, alloc_phy_1  in  PHY_WIDTH each  combinational allocated register from freelist buses 0/1
  retire_valid  in  1  one instruction with destination commits
  retire_rd_arch  in  ARCH_WIDTH  committed destination
  retire_rd_phy  in  PHY_WIDTH  committed physical mapping
  out_valid_0/1  out  1 each  renamed slot valid
  out_rd_we_0/1  out  1 each  renamed slot allocates a destination
  out_rs1_phy_0/1, out_rs2_phy_0/1, out_rd_phy_new_0/1, out_rd_phy_old_0/1  out  PHY_WIDTH each  renamed operands
  out_ready  in  1  downstream (dispatch/ROB) accepts output register

Function
REQ-003 SHALL hold a speculative map table (SRAT) and a committed map table (CRAT), ARCH_REGS x PHY_WIDTH each.
REQ-004 need_k SHALL equal in_valid_k & in_rd_we_k & (in_rd_arch_k != 0); arch x0 SHALL never allocate and always reads phys 0.
REQ-005 needed SHALL equal need_0 + need_1 (0..2).
REQ-006 in_ready SHALL equal !flush & !rst & (no out_valid set | out_ready) & (free_count >= needed).
REQ-007 fire SHALL equal in_ready & (in_valid_0 | in_valid_1).
REQ-008 alloc_req_k SHALL equal fire & need_k, combinationally, same cycle; slot 0 new phys = alloc_phy_0, slot 1 new phys = alloc_phy_1.
REQ-009 Source lookup SHALL read SRAT (pre-update value) combinationally; slot 1 rs1/rs2 equal to in_rd_arch_0 with need_0 SHALL instead take slot 0's new phys.
REQ-010 rd_phy_old_0 SHALL be SRAT[in_rd_arch_0]; rd_phy_old_1 SHALL be slot 0's new phys if need_0 and same rd, else SRAT[in_rd_arch_1].
REQ-011 On fire, SRAT[rd_k] SHALL be written with new phys for each need_k; if both target the same rd, slot 1 value wins.
REQ-012 Output register SHALL load on fire (latency 1 cycle); out_rd_we_k = need_k; for slots without need_k, out_rd_phy_new/old_k SHALL be 0.
REQ-013 With no fire and out_ready high, out_valid_0/1 SHALL clear; with out_ready low, output register SHALL hold all fields stable.
REQ-014 On retire_valid with retire_rd_arch != 0, CRAT[retire_rd_arch] SHALL update to retire_rd_phy; writes to entry 0 SHALL be ignored.
REQ-015 On flush: no fire, no allocation, out_valid_0/1 cleared, SRAT <= CRAT including any same-cycle retire update.
REQ-016 in_valid_1 without in_valid_0 SHALL be renamed as a single slot-1 instruction with no intra-bundle bypass.
REQ-017 free_count below needed SHALL stall the whole bundle (no partial rename).

Reset
REQ-018 On rst, SRAT[i] and CRAT[i] SHALL equal i for all i; out_valid_0/1 and all out fields SHALL be 0; alloc_req_0/1 SHALL be 0; rst SHALL dominate flush, fire and retire.

Verification
REQ-019 After reset, slot0 add x5<-x1,x2, slot1 x6<-x5,x5, free_count=32, alloc_phy=32/33 -> next cycle out_rs1_phy_0=1, out_rs2_phy_0=2, out_rd_phy_new_0=32, old_0=5; out_rs1/rs2_phy_1=32, new_1=33, old_1=6.
REQ-020 Both slots write x7, alloc_phy 40/41 -> old_1=40; later read of x7 yields 41.
REQ-021 free_count=1 with needed=2 -> in_ready=0, alloc_req_0/1=0, SRAT unchanged; free_count=2 next cycle -> fires.
REQ-022 out_ready held 0 for 3 cycles with valid output -> outputs stable, in_ready=0, no allocation.
REQ-023 Rename x5->32, retire x5->32, rename x5->34, flush -> x5 reads 32, out_valid cleared; retire and flush same cycle of x9->50 -> x9 reads 50.
REQ-024 rd=x0 with rd_we=1 -> alloc_req=0, out_rd_we=0, rs reading x0 yields phys 0.
